// File: rtl/turn_sequencer_pkg.sv
// Shared types, piece codes and board helpers for the chess turn sequencer.
package turn_sequencer_pkg;

    // Top-level screen FSM states; the sequencer is only active on CHESS_SCREEN.
    typedef enum logic [1:0] {
        MENU_SCREEN  = 2'd0,
        CHESS_SCREEN = 2'd1,
        END_SCREEN   = 2'd2
    } screen_state_t;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        APPLY     = 3'd2,
        SEND      = 3'd3,
        GAME_OVER = 3'd4
    } seq_state_t;

    // Board is indexed [y][x]; each square holds a 4-bit piece code.
    typedef logic [7:0][7:0][3:0] board_t;

    // Packet layout: {old_x, old_y, new_x, new_y}, 3 bits each.
    typedef logic [11:0] packet_t;

    // Piece codes. Player 1 owns 0..5, player 0 owns the same pieces at +6.
    localparam logic [3:0] PAWN_P1   = 4'd0;
    localparam logic [3:0] KNIGHT_P1 = 4'd1;
    localparam logic [3:0] BISHOP_P1 = 4'd2;
    localparam logic [3:0] ROOK_P1   = 4'd3;
    localparam logic [3:0] KING_P1   = 4'd4;
    localparam logic [3:0] QUEEN_P1  = 4'd5;
    localparam logic [3:0] PAWN_P0   = 4'd6;
    localparam logic [3:0] KING_P0   = 4'd10;
    localparam logic [3:0] QUEEN_P0  = 4'd11;
    localparam logic [3:0] EMPTY     = 4'd15;
    localparam logic [3:0] P0_OFFSET = 4'd6;

    // Back-rank piece (player 1 codes) for a given file: R N B Q K B N R.
    function automatic logic [3:0] back_piece(input logic [2:0] x);
        logic [3:0] p;
        case (x)
            3'd0, 3'd7: p = ROOK_P1;
            3'd1, 3'd6: p = KNIGHT_P1;
            3'd2, 3'd5: p = BISHOP_P1;
            3'd3:       p = QUEEN_P1;
            3'd4:       p = KING_P1;
            default:    p = EMPTY;
        endcase
        return p;
    endfunction

    // Starting position: player 1 on rows 0/1, player 0 on rows 6/7.
    function automatic board_t initial_board();
        board_t b;
        logic [2:0] xi;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                b[y][x] = EMPTY;
            end
        end
        for (int x = 0; x < 8; x++) begin
            xi          = 3'(x);
            b[0][xi]    = back_piece(xi);
            b[1][xi]    = PAWN_P1;
            b[6][xi]    = PAWN_P0;
            b[7][xi]    = back_piece(xi) + P0_OFFSET;
        end
        return b;
    endfunction

    // True when a code is 12..15 (illegal codes count as empty).
    function automatic logic is_empty(input logic [3:0] code);
        return (code >= 4'd12);
    endfunction

    // True when the piece code belongs to the given colour.
    function automatic logic owned_by(input logic [3:0] code, input logic who);
        logic r;
        if (who) begin
            r = (code <= 4'd5);
        end else begin
            r = (code >= 4'd6) && (code <= 4'd11);
        end
        return r;
    endfunction

endpackage

// File: rtl/turn_sequencer_move_screen.sv
// Combinational legality pre-check of a move packet against the current board.
module turn_sequencer_move_screen
    import turn_sequencer_pkg::*;
(
    input  board_t  board,
    input  packet_t packet,
    input  logic    mover,
    output logic    ok
);

    logic [2:0] ox_s, oy_s, nx_s, ny_s;
    logic [3:0] src_s, dst_s;

    assign ox_s  = packet[11:9];
    assign oy_s  = packet[8:6];
    assign nx_s  = packet[5:3];
    assign ny_s  = packet[2:0];
    assign src_s = board[oy_s][ox_s];
    assign dst_s = board[ny_s][nx_s];

    // Reject null moves, empty/foreign sources and self-captures.
    always_comb begin
        ok = 1'b0;
        if ((ox_s == nx_s) && (oy_s == ny_s)) begin
            ok = 1'b0;
        end else if (is_empty(src_s)) begin
            ok = 1'b0;
        end else if (!owned_by(src_s, mover)) begin
            ok = 1'b0;
        end else if (owned_by(dst_s, mover)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Owns the chess board and turn token; arbitrates local/remote moves,
// commits them, forwards local moves to the link and detects king capture.
module turn_sequencer
    import turn_sequencer_pkg::*;
#(
    parameter bit PROMOTE_EN = 1'b1,
    parameter int MOVE_CNT_W = 10
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  screen_state_t         sys_state,
    input  logic                  player,
    input  logic                  moved,
    input  logic [11:0]           local_packet,
    input  logic                  rx_valid,
    input  logic [11:0]           rx_packet,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [11:0]           tx_packet,
    output board_t                stable_board,
    output logic                  curr_player,
    output logic                  won,
    output logic                  winner,
    output logic [MOVE_CNT_W-1:0] move_count,
    output logic                  move_err
);

    localparam logic [MOVE_CNT_W-1:0] CNT_MAX = {MOVE_CNT_W{1'b1}};
    localparam logic [MOVE_CNT_W-1:0] CNT_ONE = {{(MOVE_CNT_W-1){1'b0}}, 1'b1};

    seq_state_t state_r, state_next_s;

    // Latched accepted move and where it came from.
    packet_t pkt_r;
    logic    src_local_r;

    // Candidate selection in WAIT_MOVE.
    logic    take_local_s, take_remote_s, cand_s, stray_s, screen_ok_s;
    packet_t screen_pkt_s;

    // Control strobes from the FSM to the datapath.
    logic load_init_s, latch_s, commit_s, err_s, tx_done_s, leave_s;

    // APPLY-stage decode of the latched packet.
    logic [2:0] a_ox_s, a_oy_s, a_nx_s, a_ny_s;
    logic [3:0] src_a_s, dst_a_s, placed_s;
    logic       king_hit_s;

    assign take_local_s  = moved && (curr_player == player);
    assign take_remote_s = rx_valid && (curr_player != player);
    assign cand_s        = take_local_s || take_remote_s;
    assign stray_s       = (moved && !take_local_s) || (rx_valid && !take_remote_s);
    assign screen_pkt_s  = take_local_s ? local_packet : rx_packet;

    turn_sequencer_move_screen u_move_screen (
        .board  (stable_board),
        .packet (screen_pkt_s),
        .mover  (curr_player),
        .ok     (screen_ok_s)
    );

    assign a_ox_s     = pkt_r[11:9];
    assign a_oy_s     = pkt_r[8:6];
    assign a_nx_s     = pkt_r[5:3];
    assign a_ny_s     = pkt_r[2:0];
    assign src_a_s    = stable_board[a_oy_s][a_ox_s];
    assign dst_a_s    = stable_board[a_ny_s][a_nx_s];
    assign king_hit_s = (dst_a_s == KING_P1) || (dst_a_s == KING_P0);

    // Piece that lands on the destination, with optional pawn-to-queen promotion.
    always_comb begin
        placed_s = src_a_s;
        if (PROMOTE_EN && (src_a_s == PAWN_P1) && (a_ny_s == 3'd7)) begin
            placed_s = QUEEN_P1;
        end else if (PROMOTE_EN && (src_a_s == PAWN_P0) && (a_ny_s == 3'd0)) begin
            placed_s = QUEEN_P0;
        end else begin
            placed_s = src_a_s;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control strobes; leaving the chess screen wins over everything.
    always_comb begin
        state_next_s = state_r;
        load_init_s  = 1'b0;
        latch_s      = 1'b0;
        commit_s     = 1'b0;
        err_s        = 1'b0;
        tx_done_s    = 1'b0;
        leave_s      = 1'b0;
        if (sys_state != CHESS_SCREEN) begin
            state_next_s = IDLE;
            leave_s      = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    load_init_s  = 1'b1;
                    state_next_s = WAIT_MOVE;
                end
                WAIT_MOVE: begin
                    err_s = stray_s || (cand_s && !screen_ok_s);
                    if (cand_s && screen_ok_s) begin
                        latch_s      = 1'b1;
                        state_next_s = APPLY;
                    end else begin
                        state_next_s = WAIT_MOVE;
                    end
                end
                APPLY: begin
                    commit_s = 1'b1;
                    err_s    = moved || rx_valid;
                    if (src_local_r) begin
                        state_next_s = SEND;
                    end else if (king_hit_s) begin
                        state_next_s = GAME_OVER;
                    end else begin
                        state_next_s = WAIT_MOVE;
                    end
                end
                SEND: begin
                    err_s = moved || rx_valid;
                    if (tx_ready) begin
                        tx_done_s    = 1'b1;
                        state_next_s = won ? GAME_OVER : WAIT_MOVE;
                    end else begin
                        state_next_s = SEND;
                    end
                end
                GAME_OVER: begin
                    state_next_s = GAME_OVER;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Board, turn, score and link outputs, all registered.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable_board <= {64{EMPTY}};
            curr_player  <= 1'b0;
            won          <= 1'b0;
            winner       <= 1'b0;
            move_count   <= '0;
            tx_valid     <= 1'b0;
            tx_packet    <= 12'd0;
            move_err     <= 1'b0;
            pkt_r        <= 12'd0;
            src_local_r  <= 1'b0;
        end else begin
            move_err <= err_s;
            if (load_init_s) begin
                stable_board <= initial_board();
                curr_player  <= 1'b0;
                won          <= 1'b0;
                winner       <= 1'b0;
                move_count   <= '0;
            end
            if (latch_s) begin
                pkt_r       <= screen_pkt_s;
                src_local_r <= take_local_s;
            end
            if (commit_s) begin
                stable_board[a_ny_s][a_nx_s] <= placed_s;
                stable_board[a_oy_s][a_ox_s] <= EMPTY;
                curr_player                  <= ~curr_player;
                if (move_count != CNT_MAX) begin
                    move_count <= move_count + CNT_ONE;
                end
                if (king_hit_s) begin
                    won    <= 1'b1;
                    winner <= curr_player;
                end
                if (src_local_r) begin
                    tx_valid  <= 1'b1;
                    tx_packet <= pkt_r;
                end
            end
            if (tx_done_s || leave_s) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer; a second instance without promotion
// shares every input so the two boards only differ on promoting moves.
module tb_turn_sequencer;
    import turn_sequencer_pkg::*;

    logic          CLOCK_50;
    logic          reset;
    screen_state_t sys_state;
    logic          player, moved, rx_valid, tx_ready;
    logic [11:0]   local_packet, rx_packet;

    logic          tx_valid_a, curr_a, won_a, winner_a, err_a;
    logic [11:0]   tx_packet_a;
    board_t        board_a;
    logic [9:0]    count_a;

    logic          tx_valid_b, curr_b, won_b, winner_b, err_b;
    logic [11:0]   tx_packet_b;
    board_t        board_b;
    logic [9:0]    count_b;

    int n_cmp = 0;
    int n_err = 0;

    turn_sequencer #(.PROMOTE_EN(1'b1), .MOVE_CNT_W(10)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .sys_state(sys_state), .player(player),
        .moved(moved), .local_packet(local_packet), .rx_valid(rx_valid),
        .rx_packet(rx_packet), .tx_ready(tx_ready), .tx_valid(tx_valid_a),
        .tx_packet(tx_packet_a), .stable_board(board_a), .curr_player(curr_a),
        .won(won_a), .winner(winner_a), .move_count(count_a), .move_err(err_a)
    );

    turn_sequencer #(.PROMOTE_EN(1'b0), .MOVE_CNT_W(10)) dut_np (
        .CLOCK_50(CLOCK_50), .reset(reset), .sys_state(sys_state), .player(player),
        .moved(moved), .local_packet(local_packet), .rx_valid(rx_valid),
        .rx_packet(rx_packet), .tx_ready(tx_ready), .tx_valid(tx_valid_b),
        .tx_packet(tx_packet_b), .stable_board(board_b), .curr_player(curr_b),
        .won(won_b), .winner(winner_b), .move_count(count_b), .move_err(err_b)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic logic [11:0] pk(input int ox, input int oy, input int nx, input int ny);
        return {3'(ox), 3'(oy), 3'(nx), 3'(ny)};
    endfunction

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; sys_state = MENU_SCREEN; player = 1'b0; moved = 1'b0;
        rx_valid = 1'b0; tx_ready = 1'b0; local_packet = 12'd0; rx_packet = 12'd0;
        tick(); tick();
        chk("rst_board33", 32'(board_a[3][3]), 32'd15);
        chk("rst_board04", 32'(board_a[0][4]), 32'd15);
        chk("rst_curr", 32'(curr_a), 32'd0);
        chk("rst_won", 32'(won_a), 32'd0);
        chk("rst_txv", 32'(tx_valid_a), 32'd0);
        chk("rst_txp", 32'(tx_packet_a), 32'd0);
        chk("rst_cnt", 32'(count_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        reset = 1'b0;
        tick();
        chk("menu_no_load", 32'(board_a[0][4]), 32'd15);

        // 1: enter the chess screen, layout loads on one edge
        sys_state = CHESS_SCREEN;
        tick();
        chk("init_04", 32'(board_a[0][4]), 32'd4);
        chk("init_74", 32'(board_a[7][4]), 32'd10);
        chk("init_33", 32'(board_a[3][3]), 32'd15);
        chk("init_00", 32'(board_a[0][0]), 32'd3);
        chk("init_73", 32'(board_a[7][3]), 32'd11);
        chk("init_curr", 32'(curr_a), 32'd0);

        // 2: local move by player 0, then held TX handshake
        moved = 1'b1; local_packet = pk(4, 6, 4, 4);
        tick();
        moved = 1'b0;
        chk("lat_not_yet", 32'(board_a[6][4]), 32'd6);
        tick();
        chk("l_dst", 32'(board_a[4][4]), 32'd6);
        chk("l_src", 32'(board_a[6][4]), 32'd15);
        chk("l_curr", 32'(curr_a), 32'd1);
        chk("l_cnt", 32'(count_a), 32'd1);
        chk("l_txv", 32'(tx_valid_a), 32'd1);
        chk("l_txp", 32'(tx_packet_a), 32'(pk(4, 6, 4, 4)));
        tick(); tick(); tick();
        chk("tx_hold_v", 32'(tx_valid_a), 32'd1);
        chk("tx_hold_p", 32'(tx_packet_a), 32'(pk(4, 6, 4, 4)));
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("tx_clear", 32'(tx_valid_a), 32'd0);

        // 3: remote move accepted, simultaneous local pulse dropped
        rx_valid = 1'b1; rx_packet = pk(4, 1, 4, 3);
        moved = 1'b1; local_packet = pk(3, 6, 3, 4);
        tick();
        rx_valid = 1'b0; moved = 1'b0;
        chk("r_stray_err", 32'(err_a), 32'd1);
        tick();
        chk("r_err_clr", 32'(err_a), 32'd0);
        chk("r_dst", 32'(board_a[3][4]), 32'd0);
        chk("r_src", 32'(board_a[1][4]), 32'd15);
        chk("r_stray_src", 32'(board_a[6][3]), 32'd6);
        chk("r_stray_dst", 32'(board_a[4][3]), 32'd15);
        chk("r_no_tx", 32'(tx_valid_a), 32'd0);
        chk("r_curr", 32'(curr_a), 32'd0);
        chk("r_cnt", 32'(count_a), 32'd2);

        // 4: illegal remote packets (local colour now 1, so remote plays as 0)
        player = 1'b1;
        rx_valid = 1'b1; rx_packet = pk(3, 3, 3, 2);
        tick();
        chk("d_empty_err", 32'(err_a), 32'd1);
        rx_packet = pk(0, 6, 0, 6);
        tick();
        chk("d_same_err", 32'(err_a), 32'd1);
        rx_packet = pk(4, 0, 4, 2);
        tick();
        chk("d_foreign_err", 32'(err_a), 32'd1);
        rx_packet = pk(0, 7, 0, 6);
        tick();
        chk("d_own_dst_err", 32'(err_a), 32'd1);
        rx_valid = 1'b0;
        tick();
        chk("d_err_pulse", 32'(err_a), 32'd0);
        chk("d_board32", 32'(board_a[2][3]), 32'd15);
        chk("d_board60", 32'(board_a[6][0]), 32'd6);
        chk("d_board70", 32'(board_a[7][0]), 32'd9);
        chk("d_cnt", 32'(count_a), 32'd2);
        chk("d_curr", 32'(curr_a), 32'd0);

        // 5: player-0 pawn reaches row 1, then promotes capturing the rook
        rx_valid = 1'b1; rx_packet = pk(0, 6, 0, 1);
        tick(); rx_valid = 1'b0; tick();
        chk("p_pawn_10", 32'(board_a[1][0]), 32'd6);
        chk("p_curr1", 32'(curr_a), 32'd1);
        moved = 1'b1; local_packet = pk(7, 1, 7, 2);
        tick(); moved = 1'b0; tick();
        chk("p_local_27", 32'(board_a[2][7]), 32'd0);
        tx_ready = 1'b1;
        tick(); tx_ready = 1'b0;
        chk("p_cnt4", 32'(count_a), 32'd4);
        rx_valid = 1'b1; rx_packet = pk(0, 1, 0, 0);
        tick(); rx_valid = 1'b0; tick();
        chk("p_promote", 32'(board_a[0][0]), 32'd11);
        chk("p_nopromote", 32'(board_b[0][0]), 32'd6);
        chk("p_src", 32'(board_a[1][0]), 32'd15);
        chk("p_cnt5", 32'(count_a), 32'd5);

        // 6: king capture by local player 0, GAME_OVER after SEND
        moved = 1'b1; local_packet = pk(6, 1, 6, 2);
        tick(); moved = 1'b0; tick();
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        chk("k_curr0", 32'(curr_a), 32'd0);
        player = 1'b0;
        moved = 1'b1; local_packet = pk(3, 7, 4, 0);
        tick(); moved = 1'b0; tick();
        chk("k_won", 32'(won_a), 32'd1);
        chk("k_winner", 32'(winner_a), 32'd0);
        chk("k_board04", 32'(board_a[0][4]), 32'd11);
        chk("k_txv", 32'(tx_valid_a), 32'd1);
        chk("k_cnt", 32'(count_a), 32'd7);
        rx_valid = 1'b1; rx_packet = pk(1, 0, 2, 2);
        tick(); rx_valid = 1'b0;
        chk("k_send_drop_err", 32'(err_a), 32'd1);
        chk("k_send_hold", 32'(tx_valid_a), 32'd1);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        chk("k_tx_done", 32'(tx_valid_a), 32'd0);
        rx_valid = 1'b1; rx_packet = pk(1, 0, 2, 2);
        tick(); rx_valid = 1'b0;
        chk("go_no_err", 32'(err_a), 32'd0);
        tick();
        chk("go_frozen", 32'(board_a[0][1]), 32'd1);
        chk("go_cnt", 32'(count_a), 32'd7);
        chk("go_curr", 32'(curr_a), 32'd1);

        // Leave and re-enter the chess screen
        sys_state = MENU_SCREEN;
        tick();
        chk("leave_kept", 32'(board_a[0][4]), 32'd11);
        sys_state = CHESS_SCREEN;
        tick();
        chk("re_04", 32'(board_a[0][4]), 32'd4);
        chk("re_73", 32'(board_a[7][3]), 32'd11);
        chk("re_won", 32'(won_a), 32'd0);
        chk("re_cnt", 32'(count_a), 32'd0);
        chk("re_curr", 32'(curr_a), 32'd0);

        // Leaving during SEND drops tx_valid
        moved = 1'b1; local_packet = pk(1, 7, 2, 5);
        tick(); moved = 1'b0; tick();
        chk("ls_txv", 32'(tx_valid_a), 32'd1);
        sys_state = MENU_SCREEN;
        tick();
        chk("ls_drop", 32'(tx_valid_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
